p_seq_addsub: RTL and testbench

- Parametrised, multi-cycle adder/subtractor. Processes WIDTH-bit operands CHUNK bits per clock, least-significant slice first.
- Generalises the fixed 12-bit ripple-carry adder. Adds subtract mode, unsigned saturation, carry/borrow and signed-overflow flags, and a start/done handshake.
- Used by score, line-count and position-update logic, where a wide single-cycle carry chain would limit clock speed.

---
 rtl/p_seq_addsub.sv | 176 +++++++++++++++++
 tb/tb_p_seq_addsub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/p_seq_addsub.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : p_seq_addsub                                             |
// | Description : Multi-cycle adder/subtractor. It adds WIDTH-bit operands |
// |               CHUNK bits per clock, least-significant slice first.    |
// |               It supports subtract mode, unsigned saturation,         |
// |               carry/borrow and signed-overflow flags, and a           |
// |               start/done handshake.                                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module p_seq_addsub #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             sat,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Operands are shifted right one slice per cycle, so the active slice
  // always sits in the low CHUNK bits.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             sat_q, sat_d;
  logic             carry_q, carry_d;
  // Each new slice enters the working sum at the top. After NCHUNK cycles
  // every slice is in its final position.
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK:0]   w_slice_sum;
  logic [WIDTH-1:0] w_slice_ext;
  logic [WIDTH-1:0] w_sum_shift;
  logic             w_c_out;
  logic             w_c_msb;
  logic             w_flag_cout;
  logic             w_last;
  logic             w_accept;

  // Slice adder and the flags derived from the final slice
  always_comb begin
    w_slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
    w_c_out     = w_slice_sum[CHUNK];
    // The carry into the MSB is recovered from the MSB sum bit. It is only
    // meaningful while the top slice is being added.
    w_c_msb     = w_slice_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    w_slice_ext = WIDTH'(w_slice_sum[CHUNK-1:0]);
    w_sum_shift = (sum_q >> CHUNK) | (w_slice_ext << (WIDTH - CHUNK));
    // In subtract mode the adder carry is the inverse of the borrow.
    w_flag_cout = sub_q ? ~w_c_out : w_c_out;
    w_last      = (state_q == RUN) && (cnt_q == C_LAST);
    // The final-slice cycle also accepts a new request, so the next
    // operation overlaps with the write-back of the current one.
    ready       = (state_q == IDLE) || w_last;
    w_accept    = start && ready;
  end

  // Next-state logic: slice stepping, write-back and request acceptance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = w_c_out;
        sum_d   = w_sum_shift;
        cnt_d   = cnt_q + CW'(1);
        if (w_last) begin
          if (sat_q && w_flag_cout) begin
            s_d = sub_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
          end else begin
            s_d = w_sum_shift;
          end
          cout_d  = w_flag_cout;
          ovf_d   = w_c_msb ^ w_c_out;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Subtraction is x + ~y + 1. The +1 enters as the initial carry.
    if (w_accept) begin
      a_d     = x;
      b_d     = y ^ {WIDTH{sub}};
      sub_d   = sub;
      sat_d   = sat;
      carry_d = sub;
      cnt_d   = '0;
      sum_d   = '0;
      state_d = RUN;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_p_seq_addsub.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_p_seq_addsub                                          |
// | Description : Bench for p_seq_addsub. It drives three builds           |
// |               (CHUNK=4, 1, 12) with shared inputs and compares them    |
// |               against an arithmetic reference model.                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_p_seq_addsub;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, sub, sat;
  logic [W-1:0] x, y;

  // Index 0: CHUNK=4, index 1: CHUNK=1, index 2: CHUNK=12
  logic         rdy [3];
  logic         dn  [3];
  logic [W-1:0] so  [3];
  logic         co  [3];
  logic         ov  [3];
  int           lat_exp [3] = '{3, 12, 1};

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  p_seq_addsub #(.WIDTH(W), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .sat(sat),
    .x(x), .y(y), .ready(rdy[0]), .done(dn[0]), .s(so[0]),
    .cout(co[0]), .ovf(ov[0]));

  p_seq_addsub #(.WIDTH(W), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .sat(sat),
    .x(x), .y(y), .ready(rdy[1]), .done(dn[1]), .s(so[1]),
    .cout(co[1]), .ovf(ov[1]));

  p_seq_addsub #(.WIDTH(W), .CHUNK(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .sat(sat),
    .x(x), .y(y), .ready(rdy[2]), .done(dn[2]), .s(so[2]),
    .cout(co[2]), .ovf(ov[2]));

  // Reference: returns {cout, ovf, s} from plain arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b,
                                         input logic sb, st);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c, o;
    if (!sb) begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[W-1:0];
      c    = full[W];
      o    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = a - b;
      c = (a < b);
      o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    if (st && c) r = sb ? {W{1'b0}} : {W{1'b1}};
    return {c, o, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits for done on the CHUNK=4 build. It returns the number of edges
  // waited, or -1 if done does not appear within the bound.
  task automatic wait_done0(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dn[0]) begin
        cyc = i;
        break;
      end
    end
  endtask

  // One full operation, checked on all three builds
  task automatic run_op(input logic [W-1:0] a, b, input logic sb, st, input string tag);
    logic [W+1:0] e;
    logic [W-1:0] prev;
    int           lat [3];
    int           cyc;
    e    = model(a, b, sb, st);
    prev = so[0];
    chk({tag, ".ready_idle"}, rdy[0], 1);
    x = a; y = b; sub = sb; sat = st; start = 1'b1;
    tick();
    start = 1'b0;
    x = W'($urandom); y = W'($urandom); sub = 1'($urandom); sat = 1'($urandom);
    lat = '{-1, -1, -1};
    cyc = 0;
    chk({tag, ".ready_busy0"}, rdy[0], 0);
    chk({tag, ".done_early"}, dn[0], 0);
    while (cyc < 20 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0)) begin
      tick();
      cyc++;
      for (int k = 0; k < 3; k++) if (dn[k] && lat[k] < 0) lat[k] = cyc;
      if (cyc == 1) begin
        chk({tag, ".ready_busy1"}, rdy[0], 0);
        chk({tag, ".s_stable"}, so[0], prev);
      end
      if (cyc == 4) chk({tag, ".done_pulse"}, dn[0], 0);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.lat%0d", tag, k), lat[k], lat_exp[k]);
      chk($sformatf("%s.s%0d", tag, k), so[k], e[W-1:0]);
      chk($sformatf("%s.cout%0d", tag, k), co[k], e[W+1]);
      chk($sformatf("%s.ovf%0d", tag, k), ov[k], e[W]);
    end
  endtask

  initial begin
    int           c;
    logic [W+1:0] e;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; sat = 1'b0; x = '0; y = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.ready%0d", k), rdy[k], 1);
      chk($sformatf("rst.done%0d", k), dn[k], 0);
      chk($sformatf("rst.s%0d", k), so[k], 0);
      chk($sformatf("rst.cout%0d", k), co[k], 0);
      chk($sformatf("rst.ovf%0d", k), ov[k], 0);
    end

    // Directed cases
    run_op(12'h0FF, 12'h001, 1'b0, 1'b0, "add_basic");
    run_op(12'hFFF, 12'h001, 1'b0, 1'b0, "add_wrap");
    run_op(12'hFFF, 12'h001, 1'b0, 1'b1, "add_sat");
    run_op(12'h005, 12'h007, 1'b1, 1'b0, "sub_neg");
    run_op(12'h005, 12'h007, 1'b1, 1'b1, "sub_sat");
    run_op(12'h800, 12'h001, 1'b1, 1'b0, "sub_ovf");
    run_op(12'h7FF, 12'h001, 1'b0, 1'b0, "add_ovf");
    run_op(12'h800, 12'h800, 1'b0, 1'b1, "add_ovf_sat");

    // A start while busy is ignored
    x = 12'h123; y = 12'h456; sub = 1'b0; sat = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    x = 12'hAAA; y = 12'h555; sub = 1'b1; sat = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done0(c);
    chk("busy_ign.lat", c, 1);
    chk("busy_ign.s", so[0], 12'h579);
    chk("busy_ign.cout", co[0], 0);
    tick();
    chk("busy_ign.no_second", dn[0], 0);
    pulse_reset();

    // A start in the done cycle gives a second result NCHUNK+1 cycles later
    x = 12'h100; y = 12'h0FF; sub = 1'b1; sat = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done0(c);
    chk("b2b.first_lat", c, 3);
    chk("b2b.first_s", so[0], 12'h001);
    chk("b2b.ready_done", rdy[0], 1);
    x = 12'h321; y = 12'h123; sub = 1'b0; sat = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b.s_hold", so[0], 12'h001);
    wait_done0(c);
    chk("b2b.second_gap", c + 1, 4);
    chk("b2b.second_s", so[0], 12'h444);
    pulse_reset();

    // Reset during RUN aborts the operation
    run_op(12'h0F0, 12'h00F, 1'b0, 1'b0, "pre_abort");
    x = 12'h111; y = 12'h222; sub = 1'b0; sat = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    c = 0;
    for (int i = 0; i < 14; i++) begin
      if (dn[0] || dn[1] || dn[2]) c++;
      tick();
    end
    chk("abort.no_done", c, 0);
    chk("abort.s", so[0], 0);
    chk("abort.cout", co[0], 0);
    chk("abort.ovf", ov[0], 0);
    chk("abort.ready", rdy[0], 1);
    run_op(12'h3A5, 12'h15A, 1'b1, 1'b0, "post_abort");

    // Random regression on all three builds
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 0) rb = ~ra + W'(i % 3);
      run_op(ra, rb, 1'($urandom), 1'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
